// File: rtl/metadata_table_transmitter_pkg.sv
// Shared types and the constant record table for the metadata table transmitter.
// The live-field option (METADATA_LIVE_FIELD_EN) uses LIVE_POS and live_byte().
package metadata_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_WAIT_ACK,
      ST_WAIT_IDLE,
      ST_DONE
   } state_e;

   localparam int TABLE_ENTRIES  = 2;
   localparam int TABLE_DEPTH    = 64;
   localparam int TABLE_ADDR_W   = 6;
   localparam int LEN_W          = 7;
   localparam int ENTRY_ID       = 0;
   localparam int ENTRY_METADATA = 1;

   localparam logic [7:0] LIVE_NONE = 8'hFF;

   localparam logic [7:0] ROM_INIT [TABLE_DEPTH] = '{
      8'h31, 8'h53, 8'h4C, 8'h4F, 8'h20, 8'h00, 8'h00, 8'h00,
      8'h08, 8'h21, 8'h00, 8'h00, 8'h20, 8'h00, 8'h23, 8'h05,
      8'hF5, 8'hE1, 8'h00, 8'h01, 8'h43, 8'h79, 8'h62, 8'h65,
      8'h72, 8'h73, 8'h71, 8'h75, 8'h69, 8'h64, 8'h00, 8'h02,
      8'h30, 8'h2E, 8'h31, 8'h00, 8'h03, 8'h30, 8'h2E, 8'h31,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [TABLE_ADDR_W-1:0] START [TABLE_ENTRIES] = '{6'd0, 6'd4};
   localparam logic [LEN_W-1:0]        LEN   [TABLE_ENTRIES] = '{7'd4, 7'd37};
   // LIVE_POS marks the tag byte of the live field; its four value bytes follow it.
   localparam logic [7:0]              LIVE_POS [TABLE_ENTRIES] = '{LIVE_NONE, 8'd5};

   function automatic logic [7:0] live_byte(input logic [31:0] value, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = value[31:24];
         2'd1:    b = value[23:16];
         2'd2:    b = value[15:8];
         2'd3:    b = value[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/metadata_table_transmitter_if.sv
// Host command and serial byte bus of the metadata table transmitter.
interface metadata_table_transmitter_if #(
   parameter int ENTRY_W = 2
);
   logic               run;
   logic [ENTRY_W-1:0] entry;
   logic               abort;
   logic [31:0]        live_value;
   logic               serial_output_active;
   logic               serial_output_valid;
   logic [7:0]         serial_output_data;
   logic               busy;
   logic               finished;
   logic               error;

   modport master (
      output run, entry, abort, live_value, serial_output_active,
      input  serial_output_valid, serial_output_data, busy, finished, error
   );

   modport slave (
      input  run, entry, abort, live_value, serial_output_active,
      output serial_output_valid, serial_output_data, busy, finished, error
   );
endinterface

// File: rtl/metadata_table_transmitter_rom.sv
// Constant record table with a registered, one-cycle-latency read port.
module metadata_rom
   import metadata_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clock,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [7:0]        data_o
);
   logic [7:0] data_q;

   // No reset on the read register so the table can map onto block RAM.
   always_ff @(posedge clock) begin
      if (int'(addr_i) < DEPTH) begin
         data_q <= ROM_INIT[addr_i];
      end else begin
         data_q <= 8'h00;
      end
   end

   assign data_o = data_q;
endmodule

// File: rtl/metadata_table_transmitter.sv
// Streams one table record byte-by-byte to the serial transmitter with a per-byte handshake.
// Optional build macro METADATA_LIVE_FIELD_EN splices a latched runtime word into a record.
module metadata_table_transmitter
   import metadata_pkg::*;
#(
   parameter int NUM_ENTRIES = 2,
   parameter int ENTRY_W     = 2,
   parameter int ROM_DEPTH   = 64,
   parameter int ADDR_W      = 6
) (
   input logic                         clock,
   input logic                         reset,
   metadata_table_transmitter_if.slave bus
);
   logic [ENTRY_W-1:0] entry_s;
   logic               entry_ok_s;
   logic [ADDR_W-1:0]  entry_start_s;
   logic [LEN_W-1:0]   entry_len_s;
   logic [7:0]         entry_live_pos_s;
   logic               accept_s;
   logic [7:0]         rom_data_s;
   logic [7:0]         tx_byte_s;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   count_q, count_d;
   logic               valid_q, valid_d;
   logic [7:0]         data_q, data_d;
   logic               busy_q, busy_d;
   logic               finished_q, finished_d;
   logic               error_q, error_d;

   assign entry_s  = bus.entry;
   assign accept_s = (state_q == ST_IDLE) && bus.run && !bus.abort;

   // Table lookup; selects at or beyond NUM_ENTRIES leave entry_ok_s low.
   always_comb begin
      entry_ok_s       = 1'b0;
      entry_start_s    = '0;
      entry_len_s      = '0;
      entry_live_pos_s = LIVE_NONE;
      for (int i = 0; i < NUM_ENTRIES && i < TABLE_ENTRIES; i++) begin
         entry_ok_s       = entry_ok_s | (entry_s == ENTRY_W'(i));
         entry_start_s    = entry_start_s | ((entry_s == ENTRY_W'(i)) ? ADDR_W'(START[i]) : '0);
         entry_len_s      = entry_len_s | ((entry_s == ENTRY_W'(i)) ? LEN[i] : '0);
         entry_live_pos_s = (entry_s == ENTRY_W'(i)) ? LIVE_POS[i] : entry_live_pos_s;
      end
   end

   // The ROM is addressed with the next address so data is ready during FETCH.
   metadata_rom #(
      .DEPTH  (ROM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .clock  (clock),
      .addr_i (addr_d),
      .data_o (rom_data_s)
   );

`ifdef METADATA_LIVE_FIELD_EN
   logic [31:0]       live_q;
   logic [ADDR_W-1:0] start_q;
   logic [7:0]        live_pos_q;
   logic [7:0]        live_rel_s;

   // Capture the runtime word and record geometry on run acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         live_q     <= 32'h0000_0000;
         start_q    <= '0;
         live_pos_q <= LIVE_NONE;
      end else if (accept_s && entry_ok_s) begin
         live_q     <= bus.live_value;
         start_q    <= entry_start_s;
         live_pos_q <= entry_live_pos_s;
      end else begin
         live_q     <= live_q;
         start_q    <= start_q;
         live_pos_q <= live_pos_q;
      end
   end

   // Negative offsets wrap to large values and fall outside the 4-byte window.
   always_comb begin
      live_rel_s = 8'(addr_q - start_q) - live_pos_q - 8'd1;
      if ((live_pos_q != LIVE_NONE) && (live_rel_s < 8'd4)) begin
         tx_byte_s = live_byte(live_q, live_rel_s[1:0]);
      end else begin
         tx_byte_s = rom_data_s;
      end
   end
`else
   assign tx_byte_s = rom_data_s;
`endif

   // Valid is registered: it rises on the FETCH->SEND edge, so SEND is the strobe cycle.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      busy_d     = busy_q;
      finished_d = 1'b0;
      error_d    = 1'b0;
      if (bus.abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && entry_ok_s) begin
                  busy_d = 1'b1;
                  addr_d = entry_start_s;
                  if (entry_len_s == '0) begin
                     count_d    = '0;
                     finished_d = 1'b1;
                     state_d    = ST_DONE;
                  end else begin
                     count_d = entry_len_s - 7'd1;
                     state_d = ST_FETCH;
                  end
               end else if (accept_s) begin
                  error_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (!bus.serial_output_active) begin
                  valid_d = 1'b1;
                  data_d  = tx_byte_s;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_SEND: begin
               state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (bus.serial_output_active) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  state_d = ST_WAIT_ACK;
               end
            end
            ST_WAIT_IDLE: begin
               if (bus.serial_output_active) begin
                  state_d = ST_WAIT_IDLE;
               end else if (count_q != '0) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  count_d = count_q - 7'd1;
                  state_d = ST_FETCH;
               end else begin
                  finished_d = 1'b1;
                  state_d    = ST_DONE;
               end
            end
            ST_DONE: begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         data_q     <= 8'h00;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         finished_q <= finished_d;
         error_q    <= error_d;
      end
   end

   assign bus.serial_output_valid = valid_q;
   assign bus.serial_output_data  = data_q;
   assign bus.busy                = busy_q;
   assign bus.finished            = finished_q;
   assign bus.error               = error_q;
endmodule

// File: tb/tb_metadata_table_transmitter.sv
// Self-checking bench: directed and randomized runs against a record-level reference model.
module tb_metadata_table_transmitter;
   typedef logic [7:0] bq_t [$];

   logic clock;
   logic reset;
   metadata_table_transmitter_if #(.ENTRY_W(2)) bus ();

   metadata_table_transmitter #(
      .NUM_ENTRIES (2),
      .ENTRY_W     (2),
      .ROM_DEPTH   (64),
      .ADDR_W      (6)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bq_t  rx_q;
   int   fin_cnt, err_cnt, busy_cnt, first_valid_cyc, fin_cyc, err_cyc;
   int   ack_delay = 1;
   int   hold = 10;
   int   tx_fall_cyc = 0;
   bit   tx_busy = 1'b0;
   int   run_entry, run_cyc;
   logic [31:0] run_live;

   always @(negedge clock) begin
      if (bus.serial_output_valid) begin
         if (rx_q.size() == 0) first_valid_cyc = cyc;
         rx_q.push_back(bus.serial_output_data);
      end
      if (bus.finished) begin
         fin_cnt++;
         fin_cyc = cyc;
      end
      if (bus.error) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;
   end

   // Transmitter model: raise active ack_delay cycles after a strobe, hold it for hold cycles.
   initial begin
      bus.serial_output_active = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.serial_output_valid) begin
            tx_busy = 1'b1;
            for (int i = 0; i < ack_delay; i++) @(negedge clock);
            bus.serial_output_active = 1'b1;
            for (int i = 0; i < hold; i++) @(negedge clock);
            bus.serial_output_active = 1'b0;
            tx_fall_cyc = cyc;
            tx_busy = 1'b0;
         end
      end
   end

   function automatic bq_t model(input int e, input logic [31:0] live);
      bq_t q;
      string s;
      string names [3];
      logic [7:0]  tags [3];
      logic [31:0] vals [3];
      logic [31:0] w;
      names = '{"Cybersquid", "0.1", "0.1"};
      tags  = '{8'h20, 8'h21, 8'h23};
      vals  = '{32'h0000_0008, 32'h0000_2000, 32'h05F5_E100};
      if (e == 0) begin
         s = "1SLO";
         for (int c = 0; c < s.len(); c++) q.push_back(s[c]);
      end else if (e == 1) begin
         for (int i = 0; i < 3; i++) begin
            q.push_back(tags[i]);
            w = vals[i];
`ifdef METADATA_LIVE_FIELD_EN
            if (i == 1) w = live;
`endif
            for (int k = 0; k < 4; k++) q.push_back(w[31 - 8*k -: 8]);
         end
         for (int i = 0; i < 3; i++) begin
            q.push_back(8'(i + 1));
            for (int c = 0; c < names[i].len(); c++) q.push_back(names[i][c]);
            q.push_back(8'h00);
         end
      end
      return q;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_quiet();
      for (int i = 0; i < 500 && (tx_busy || bus.serial_output_active); i++) @(negedge clock);
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      for (int i = 0; i < 4000 && rx_q.size() < n; i++) @(negedge clock);
      check({tag, "_reach"}, 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic start_run(input int e, input logic [31:0] live);
      wait_quiet();
      @(posedge clock);
      #1;
      rx_q.delete();
      fin_cnt = 0;
      err_cnt = 0;
      busy_cnt = 0;
      @(negedge clock);
      run_entry = e;
      run_live = live;
      run_cyc = cyc;
      bus.run = 1'b1;
      bus.entry = 2'(e);
      bus.live_value = live;
      @(negedge clock);
      bus.run = 1'b0;
      bus.live_value = $urandom;
   endtask

   task automatic finish_checks(input string tag);
      bq_t exp;
      bit ok_e;
      ok_e = (run_entry < 2);
      for (int i = 0; i < 4000 && fin_cnt == 0 && err_cnt == 0; i++) @(negedge clock);
      wait_quiet();
      repeat (6) @(negedge clock);
      exp = model(run_entry, run_live);
      check({tag, "_finished"}, 32'(fin_cnt), 32'(ok_e));
      check({tag, "_error"}, 32'(err_cnt), 32'(!ok_e));
      check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
      end
      if (ok_e) begin
         check({tag, "_first_lat"}, 32'(first_valid_cyc - run_cyc), 32'd2);
         check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(fin_cyc - run_cyc));
         check({tag, "_fin_after_fall"}, 32'(fin_cyc), 32'(tx_fall_cyc + 1));
      end else begin
         check({tag, "_err_lat"}, 32'(err_cyc - run_cyc), 32'd1);
         check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd0);
      end
   endtask

   initial begin
      bus.run = 1'b0;
      bus.entry = 2'd0;
      bus.abort = 1'b0;
      bus.live_value = 32'h0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_valid", 32'(bus.serial_output_valid), 32'd0);
      check("rst_data", 32'(bus.serial_output_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_finished", 32'(bus.finished), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      ack_delay = 1;
      hold = 10;
      start_run(0, $urandom);
      finish_checks("id");

      start_run(1, 32'h0000_4000);
      finish_checks("meta_live");

      // Late acknowledge plus a run pulse while busy, which must be ignored.
      ack_delay = 3;
      hold = 5;
      start_run(1, $urandom);
      wait_bytes(3, "race");
      bus.run = 1'b1;
      bus.entry = 2'd0;
      @(negedge clock);
      bus.run = 1'b0;
      finish_checks("race");

      ack_delay = 1;
      hold = 4;
      start_run(2, $urandom);
      finish_checks("inv2");
      start_run(3, $urandom);
      finish_checks("inv3");

      start_run(1, $urandom);
      wait_bytes(10, "abort");
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      wait_quiet();
      repeat (20) @(negedge clock);
      check("abort_nbytes", 32'(rx_q.size()), 32'd10);
      check("abort_finished", 32'(fin_cnt), 32'd0);
      check("abort_error", 32'(err_cnt), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      start_run(0, $urandom);
      finish_checks("after_abort");

      start_run(1, $urandom);
      wait_bytes(5, "midrst");
      reset = 1'b1;
      @(negedge clock);
      check("midrst_valid", 32'(bus.serial_output_valid), 32'd0);
      check("midrst_data", 32'(bus.serial_output_data), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_finished", 32'(bus.finished), 32'd0);
      check("midrst_error", 32'(bus.error), 32'd0);
      reset = 1'b0;
      wait_quiet();
      repeat (20) @(negedge clock);
      check("midrst_nbytes", 32'(rx_q.size()), 32'd5);
      check("midrst_fin", 32'(fin_cnt), 32'd0);
      start_run(0, $urandom);
      finish_checks("after_rst");

      for (int it = 0; it < 8; it++) begin
         ack_delay = $urandom_range(1, 4);
         hold = $urandom_range(1, 12);
         start_run($urandom_range(0, 3), $urandom);
         finish_checks($sformatf("rnd%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
